stream_mux: RTL and testbench
=============================

# stream_mux

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake on every input and on the output. It is the successor of the CPU's combinational 2:1 byte mux for datapaths that cross pipeline stages or share one consumer among several producers (bus masters, writeback sources). It selects either a fixed channel from `sel` or arbitrates round-robin, and holds the chosen beat in an output register until the consumer accepts it.

## Interface
- `WIDTH`, 8, data width in bits (≥1)
- `NCH`, 4, number of input channels (≥2, need not be a power of two)
- `MODE`, 0, 0 = fixed select from `sel`; 1 = round-robin arbitration (`sel` ignored)
- `SELW`, `$clog2(NCH)`, derived select/channel-index width; not overridden
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `in_data`  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- `in_valid`  in  NCH  per-channel beat available
- `in_ready`  out  NCH  per-channel accept; at most one bit high per cycle
- `sel`  in  SELW  channel select, MODE 0 only
- `out_data`  out  WIDTH  registered selected beat
- `out_chan`  out  SELW  source channel index of `out_data`
- `out_valid`  out  1  output register holds a beat
- `out_ready`  in  1  consumer accepts the beat

## Operation
- `load_en = !out_valid || out_ready`: the output register may load this cycle.
- Grant, combinational, evaluated only when `load_en`:
  - MODE 0: grant = `sel` if `sel < NCH` and `in_valid[sel]`; otherwise no grant. An out-of-range `sel` never grants.
  - MODE 1: grant = first i with `in_valid[i]`, scanning from `rr_ptr` upward and wrapping at NCH−1 → 0.
- `in_ready[i] = rst_n && load_en && grant_valid && grant == i`. An input transfer occurs when `in_valid[i] && in_ready[i]`.
- On an input transfer:
  - `out_data <= in_data[grant]`, `out_chan <= grant`, `out_valid <= 1`.
  - MODE 1 only: `rr_ptr <= (grant == NCH−1) ? 0 : grant+1`.
- `load_en` with no grant: `out_valid <= 0`. `out_data` and `out_chan` hold their previous values.
- `!load_en` (output stalled): all registers hold and every `in_ready` is 0.
- A producer may drop `in_valid` before it is accepted. No beat is lost or duplicated, since transfer requires both signals in the same cycle.
- Beats are never reordered within a channel. Across channels, order is the grant order.

## Timing
- Reset (`rst_n` low at a clock edge): `out_valid` = 0, `out_data` = 0, `out_chan` = 0, `rr_ptr` = 0. `in_ready` is all-zero combinationally while `rst_n` is low.
- Reset asserted mid-transfer discards the held beat. The first grant after reset starts from channel 0.
- Latency: 1 cycle from input transfer to `out_valid`/`out_data` visible.
- Throughput: 1 beat per cycle while `out_ready` is held high. There are no bubbles on a simultaneous output drain and input load.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `sel` and `rr_ptr`. `out_*` are purely registered.
- MODE 1 fairness: with all NCH channels continuously valid, each is granted exactly once per NCH consecutive transfers.
- A `sel` change takes effect on the next grant decision only. A held output beat is unaffected.

## Structure
- Shared package `mux_pkg`:
  - `MUX_MODE_FIXED = 0`, `MUX_MODE_RR = 1` constants
  - `chan_idx_t` convention (SELW-bit index) reused by future bus arbiters
- Sub-module `rr_arbiter`:
  - parameter NCH
  - inputs `req[NCH]`, `ptr[SELW]`
  - outputs `gnt_valid`, `gnt_idx[SELW]`
  - purely combinational rotate-priority search
- `stream_mux` instantiates `rr_arbiter` only when MODE 1. Pointer register, output register and handshake logic stay in `stream_mux`.
- Expected size is about 150–250 lines total.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with all `in_valid` = 1 → `out_valid` = 0, `out_data` = 0, `in_ready` = 0000 throughout. The first beat after release comes from channel 0 in MODE 1.
- **MODE 0 steady stream:** `sel` = 2, ch2 streams 0xA0, 0xA1, 0xA2 with `out_ready` = 1 → `out_data` shows A0/A1/A2 on consecutive cycles, each one cycle after its input transfer, with `out_chan` = 2. `in_ready[0,1,3]` stays 0.
- **Backpressure:** drop `out_ready` while 0x55 is held and ch1 presents 0x66 → 0x55 is held and `in_ready` = 0. Raise `out_ready` → 0x55 is consumed and 0x66 loads in the same cycle, with no bubble.
- **MODE 1 round-robin with wrap:** NCH = 3, all channels valid, `out_ready` = 1 → grant order is 0, 1, 2, 0, 1, 2. Then only ch0 and ch2 are valid with `rr_ptr` = 1 → ch2 is granted, then ch0.
- **Out-of-range select:** MODE 0, NCH = 3, `sel` = 3 → no grant, and `out_valid` falls to 0 after draining.
- **Reset mid-stall:** with `out_valid` = 1 and `out_ready` = 0, pulse `rst_n` low for one cycle → the beat is discarded, `out_valid` = 0, and `rr_ptr` = 0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared definitions for the stream multiplexer family.
//               Holds the mode constants and the channel-index wrap helper.
//               By convention, channel indices are SELW-bit values.
//               Each user declares them locally as
//                   typedef logic [SELW-1:0] chan_idx_t;
//               where SELW = $clog2(NCH) for that instance. Future bus
//               arbiters follow the same convention.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int MUX_MODE_FIXED = 0;   // channel chosen by sel
    localparam int MUX_MODE_RR    = 1;   // round-robin arbitration

    // Next channel index after idx, wrapping from nch-1 back to 0.
    function automatic int chan_next(input int idx, input int nch);
        return (idx >= nch - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational rotate-priority search. Grants the first
//               requesting channel at or after ptr, wrapping at NCH-1 -> 0.
// Ports       : req       in  NCH   per-channel request
//               ptr       in  SELW  highest-priority channel this cycle
//               gnt_valid out 1     some channel is granted
//               gnt_idx   out SELW  granted channel (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    typedef logic [SELW-1:0] chan_idx_t;

    always_comb begin
        chan_idx_t w_idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = ptr;
        // Walk all NCH positions once; the first hit wins.
        for (int k = 0; k < NCH; k++) begin
            if (!gnt_valid && req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
            w_idx = SELW'(chan_next(int'(w_idx), NCH));
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux
// Description : N-channel, W-bit registered multiplexer with valid/ready on
//               every input and on the output. It selects a fixed channel
//               from sel (MODE 0) or arbitrates round-robin (MODE 1). The
//               chosen beat is held in an output register until it is
//               accepted.
// Ports       : clk        in  1          clock, rising edge
//               rst_n      in  1          synchronous active-low reset
//               in_data    in  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//               in_valid   in  NCH        per-channel beat available
//               in_ready   out NCH        per-channel accept (one-hot or 0)
//               sel        in  SELW       fixed select (MODE 0 only)
//               out_data   out WIDTH      registered beat
//               out_chan   out SELW       source channel of out_data
//               out_valid  out 1          output register holds a beat
//               out_ready  in  1          consumer accepts the beat
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = MUX_MODE_FIXED,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef logic [SELW-1:0] chan_idx_t;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    chan_idx_t        r_out_chan;

    logic             w_load_en;
    logic             w_gnt_valid;
    chan_idx_t        w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;

    // The register can take a new beat when empty or being drained now.
    // This gives full throughput with no bubble on drain-and-load.
    assign w_load_en = !r_out_valid || out_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            chan_idx_t r_rr_ptr;

            rr_arbiter #(
                .NCH  (NCH),
                .SELW (SELW)
            ) u_arb (
                .req       (in_valid),
                .ptr       (r_rr_ptr),
                .gnt_valid (w_gnt_valid),
                .gnt_idx   (w_gnt_idx)
            );

            // Priority moves to the channel just after the one granted.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rr_ptr <= '0;
                end else if (w_xfer) begin
                    r_rr_ptr <= SELW'(chan_next(int'(w_gnt_idx), NCH));
                end
            end
        end else begin : g_fixed
            // An out-of-range sel (possible when NCH is not a power of two)
            // never grants. The range test short-circuits the index.
            assign w_gnt_valid = (int'(sel) < NCH) && in_valid[sel];
            assign w_gnt_idx   = sel;
        end
    endgenerate

    // rst_n gates the transfer so in_ready is quiet during reset.
    assign w_xfer     = rst_n && w_load_en && w_gnt_valid;
    assign w_gnt_data = in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (w_xfer) begin
            in_ready[w_gnt_idx] = 1'b1;
        end
    end

    // Output register. On a load slot with no grant, only valid drops.
    // Data and channel keep their last values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt_idx;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux
// Description : Directed self-checking bench for stream_mux. It uses three
//               instances: MODE 0 with 4 channels, MODE 1 with 3 channels,
//               and MODE 0 with 3 channels (for the out-of-range select).
//               Inputs are driven 1 time unit after the rising edge.
//               Outputs are checked 1 time unit after that.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux;

    logic clk;
    logic rst_n;

    // A: MODE 0, NCH 4
    logic [31:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel, a_out_chan;
    logic [7:0]  a_out_data;
    logic        a_out_valid, a_out_ready;

    // B: MODE 1, NCH 3
    logic [23:0] b_in_data;
    logic [2:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_out_chan;
    logic [7:0]  b_out_data;
    logic        b_out_valid, b_out_ready;

    // C: MODE 0, NCH 3
    logic [23:0] c_in_data;
    logic [2:0]  c_in_valid, c_in_ready;
    logic [1:0]  c_sel, c_out_chan;
    logic [7:0]  c_out_data;
    logic        c_out_valid, c_out_ready;

    int n_cmp;
    int n_err;

    stream_mux #(.WIDTH(8), .NCH(4), .MODE(0)) u_fix4 (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    stream_mux #(.WIDTH(8), .NCH(3), .MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    stream_mux #(.WIDTH(8), .NCH(3), .MODE(0)) u_fix3 (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_chan(c_out_chan), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0] rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [2:0] rr_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [7:0] a_stream [3] = '{8'hA0, 8'hA1, 8'hA2};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n       = 1'b0;
        a_in_data   = 32'h33_22_11_00;
        a_in_valid  = 4'b1111;
        a_sel       = 2'd0;
        a_out_ready = 1'b1;
        b_in_data   = 24'h12_11_10;
        b_in_valid  = 3'b111;
        b_sel       = 2'd0;
        b_out_ready = 1'b1;
        c_in_data   = 24'h00_00_77;
        c_in_valid  = 3'b111;
        c_sel       = 2'd0;
        c_out_ready = 1'b1;

        // ---- Reset held for three cycles with every channel valid
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_a_out_valid", a_out_valid, 1'b0);
            check_eq("rst_a_out_data", a_out_data, 8'h00);
            check_eq("rst_a_in_ready", a_in_ready, 4'b0000);
            check_eq("rst_b_in_ready", b_in_ready, 3'b000);
        end
        check_eq("rst_b_out_chan", b_out_chan, 2'd0);

        // ---- Release reset: round-robin on B starts at channel 0
        rst_n      = 1'b1;
        a_in_valid = 4'b0000;
        c_in_valid = 3'b000;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_eq($sformatf("rr_ready_%0d", i), b_in_ready, rr_rdy[i]);
            tick();
            check_eq($sformatf("rr_chan_%0d", i), b_out_chan, rr_exp[i]);
            check_eq($sformatf("rr_data_%0d", i), b_out_data, 8'h10 + rr_exp[i]);
            check_eq($sformatf("rr_valid_%0d", i), b_out_valid, 1'b1);
        end

        // Grant ch0 alone so that the pointer sits at 1.
        b_in_valid = 3'b001;
        tick();
        check_eq("rr_solo_chan", b_out_chan, 2'd0);
        // With only ch0 and ch2 valid and pointer 1, ch2 wins, then ch0.
        b_in_valid = 3'b101;
        settle();
        check_eq("rr_skip_ready", b_in_ready, 3'b100);
        tick();
        check_eq("rr_skip_chan", b_out_chan, 2'd2);
        check_eq("rr_skip_data", b_out_data, 8'h12);
        settle();
        check_eq("rr_wrap_ready", b_in_ready, 3'b001);
        tick();
        check_eq("rr_wrap_chan", b_out_chan, 2'd0);
        b_in_valid = 3'b000;
        tick();
        check_eq("rr_idle_valid", b_out_valid, 1'b0);

        // ---- MODE 0 steady stream on ch2, all channels valid
        a_sel      = 2'd2;
        a_in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            a_in_data[23:16] = a_stream[i];
            settle();
            check_eq($sformatf("fix_ready_%0d", i), a_in_ready, 4'b0100);
            tick();
            check_eq($sformatf("fix_data_%0d", i), a_out_data, a_stream[i]);
            check_eq($sformatf("fix_chan_%0d", i), a_out_chan, 2'd2);
            check_eq($sformatf("fix_valid_%0d", i), a_out_valid, 1'b1);
        end
        a_in_valid = 4'b0000;
        tick();
        check_eq("fix_drain_valid", a_out_valid, 1'b0);
        check_eq("fix_drain_data_hold", a_out_data, 8'hA2);

        // ---- Backpressure: 0x55 held, 0x66 waiting on ch1
        a_sel = 2'd1;
        a_in_valid = 4'b0010;
        a_in_data[15:8] = 8'h55;
        tick();
        check_eq("bp_first_data", a_out_data, 8'h55);
        check_eq("bp_first_chan", a_out_chan, 2'd1);
        a_out_ready = 1'b0;
        a_in_data[15:8] = 8'h66;
        settle();
        check_eq("bp_stall_ready", a_in_ready, 4'b0000);
        tick();
        check_eq("bp_hold_data", a_out_data, 8'h55);
        check_eq("bp_hold_valid", a_out_valid, 1'b1);
        tick();
        check_eq("bp_hold_data2", a_out_data, 8'h55);
        a_out_ready = 1'b1;
        settle();
        check_eq("bp_release_ready", a_in_ready, 4'b0010);
        tick();
        check_eq("bp_nobubble_data", a_out_data, 8'h66);
        check_eq("bp_nobubble_valid", a_out_valid, 1'b1);
        a_in_valid = 4'b0000;
        tick();
        check_eq("bp_drain_valid", a_out_valid, 1'b0);

        // ---- Out-of-range select on a 3-channel MODE 0 instance
        c_sel = 2'd0;
        c_in_valid = 3'b001;
        tick();
        check_eq("oor_load_data", c_out_data, 8'h77);
        check_eq("oor_load_valid", c_out_valid, 1'b1);
        c_sel = 2'd3;
        c_in_valid = 3'b111;
        settle();
        check_eq("oor_ready", c_in_ready, 3'b000);
        tick();
        check_eq("oor_valid_drop", c_out_valid, 1'b0);
        check_eq("oor_data_hold", c_out_data, 8'h77);
        tick();
        check_eq("oor_valid_stay", c_out_valid, 1'b0);
        c_in_valid = 3'b000;

        // ---- Reset during a stall on B (its pointer is 1 here)
        b_in_valid = 3'b010;
        tick();
        check_eq("mrst_load_chan", b_out_chan, 2'd1);
        check_eq("mrst_load_data", b_out_data, 8'h11);
        b_out_ready = 1'b0;
        b_in_valid  = 3'b111;
        tick();
        check_eq("mrst_stall_valid", b_out_valid, 1'b1);
        rst_n = 1'b0;
        settle();
        check_eq("mrst_ready_in_rst", b_in_ready, 3'b000);
        tick();
        check_eq("mrst_valid_clr", b_out_valid, 1'b0);
        check_eq("mrst_data_clr", b_out_data, 8'h00);
        check_eq("mrst_chan_clr", b_out_chan, 2'd0);
        rst_n = 1'b1;
        settle();
        // The pointer was 2 before reset; a one-hot on ch0 shows it cleared.
        check_eq("mrst_ptr_ready", b_in_ready, 3'b001);
        b_out_ready = 1'b1;
        tick();
        check_eq("mrst_first_chan", b_out_chan, 2'd0);
        check_eq("mrst_first_data", b_out_data, 8'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
